alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
// Multi-cycle controller that computes the low DATA_WIDTH bits of an unsigned/two's-complement product.
// - Method: shift-and-add, issuing one ADD per cycle to the shared core ALU.
// - Sits between the execute stage and the ALU as an ownership mux.
// - Idle: core operands/opcode pass straight to the ALU.
// - Busy: the sequencer drives the ALU and raises busy so the core stalls.
// PARAMETERS
// DATA_WIDTH     32  operand, product and ALU data width
// OPCODE_LENGTH  4   ALU Operation field width
// PORTS
// clk          in   1              single clock, all state updates on rising edge
// rst_n        in   1              synchronous, active-low reset
// start        in   1              request multiply; accepted only when ready=1
// flush        in   1              synchronous abort of an in-flight multiply
// op_a         in   DATA_WIDTH     multiplicand, sampled on accepted start
// op_b         in   DATA_WIDTH     multiplier, sampled on accepted start
// ready        out  1              high in IDLE only
// busy         out  1              high in BUSY only; core stall request
// done         out  1              one-cycle pulse, product valid
// product      out  DATA_WIDTH     registered result, held until next completion
// core_srca    in   DATA_WIDTH     core ALU operand A (pass-through)
// core_srcb    in   DATA_WIDTH     core ALU operand B (pass-through)
// core_op      in   OPCODE_LENGTH  core ALU opcode (pass-through)
// alu_srca     out  DATA_WIDTH     to ALU SrcA
// alu_srcb     out  DATA_WIDTH     to ALU SrcB
// alu_op       out  OPCODE_LENGTH  to ALU Operation
// alu_result   in   DATA_WIDTH     from ALU ALUResult (combinational, same cycle)
// BEHAVIOUR
// - FSM states: IDLE, BUSY, DONE.
// - Reset (rst_n=0 at edge), from any state:
//   - state=IDLE; product, acc, mcand, mplier, cnt = 0; ready=1, busy=0, done=0.
//   - ALU outputs revert to pass-through.
// - IDLE:
//   - start=1 & flush=0: latch acc=0, mcand=op_a, mplier=op_b, cnt=0; go to BUSY.
//   - flush=1: wins over start; stay in IDLE.
// - BUSY, each cycle:
//   - Drive alu_op=4'b0010 (ADD), alu_srca=acc, alu_srcb = mplier[0] ? mcand : 0.
//   - At the edge: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
//   - Exactly DATA_WIDTH cycles; no early termination on mplier==0.
//   - On the edge where cnt==DATA_WIDTH-1: product<=alu_result; go to DONE.
// - DONE: done=1 for this single cycle; ALU back to pass-through; go to IDLE next edge.
//   start during DONE is ignored (ready=0).
// - Latency, start accepted at edge T:
//   - BUSY during cycles T+1..T+DATA_WIDTH.
//   - done=1 in cycle T+DATA_WIDTH+1.
//   - ready=1 again in cycle T+DATA_WIDTH+2.
// - flush in BUSY or DONE: go to IDLE at the next edge.
//   - No done pulse, or the DONE pulse lasts only its own cycle.
//   - product unchanged unless the final BUSY edge already wrote it.
// - Arithmetic: all adds and shifts are modulo 2^DATA_WIDTH; bits shifted out of mcand are discarded.
//   The result equals the low half of the signed or unsigned product.
// - ALU mux: selected by (state==BUSY) only; purely combinational, no added latency on pass-through.
// - product, busy, ready and done are driven directly from registered state.
// TESTING
// - Reset: hold rst_n=0 two cycles mid-BUSY -> product=0, busy=0, done=0, ready=1; pass-through restored.
// - Basic: op_a=7, op_b=6, start at T -> busy T+1..T+32; done=1 at T+33 with product=42; ready=1 at T+34.
// - Wrap: 0xFFFFFFFF x 0xFFFFFFFF -> product=0x00000001; 0x00010000 x 0x00010000 -> product=0x00000000.
// - Mux: IDLE, core_op=4'b0110, core_srca=5, core_srcb=3 -> alu_op=0110, alu_srca=5, alu_srcb=3.
//   In BUSY with the same core inputs -> alu_op=0010, alu_srca=acc.
// - Flush: complete 3x4 (product=12), then start 9x9 and flush on the 10th BUSY cycle.
//   Expect IDLE next cycle, no done, product stays 12; start with flush=1 in IDLE -> not accepted.
// - Back-to-back: start held high continuously.
//   Second operation accepted only in the first IDLE cycle after DONE.
//   Second done exactly DATA_WIDTH+2 cycles after the first.

Source files
------------

// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the multiply handshake, the core-side ALU operands and the shared ALU port.
// The sequencer uses the slave view; the execute stage / environment uses the master view.
interface alu_mul_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     start;
  logic                     flush;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic                     ready;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    product;
  logic [DATA_WIDTH-1:0]    core_srca;
  logic [DATA_WIDTH-1:0]    core_srcb;
  logic [OPCODE_LENGTH-1:0] core_op;
  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport slave (
    input  start, flush, op_a, op_b, core_srca, core_srcb, core_op, alu_result,
    output ready, busy, done, product, alu_srca, alu_srcb, alu_op
  );

  modport master (
    output start, flush, op_a, op_b, core_srca, core_srcb, core_op, alu_result,
    input  ready, busy, done, product, alu_srca, alu_srcb, alu_op
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the core ALU for one ADD per cycle while busy,
// and otherwise passes the execute stage's operands and opcode straight through to the ALU.
module alu_mul_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_mul_sequencer_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [DATA_WIDTH-1:0]   acc_q,     acc_d;
  logic [DATA_WIDTH-1:0]   mcand_q,   mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q,  mplier_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0]   product_q, product_d;

  logic                    own_alu;
  logic [DATA_WIDTH-1:0]   partial;

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        // flush has priority so an abort issued alongside a new request cancels it
        if (bus.start && !bus.flush) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d    = bus.alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          // All DATA_WIDTH steps always run, even once the multiplier has drained to zero
          if (cnt_q == CNT_LAST) begin
            product_d = bus.alu_result;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ALU ownership mux: combinational so pass-through adds no latency to the core
  assign own_alu = (state_q == BUSY);
  assign partial = mplier_q[0] ? mcand_q : '0;

  assign bus.alu_op   = own_alu ? OP_ADD  : bus.core_op;
  assign bus.alu_srca = own_alu ? acc_q   : bus.core_srca;
  assign bus.alu_srcb = own_alu ? partial : bus.core_srcb;

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == BUSY);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomised bench for alu_mul_sequencer: a cycle-level model of the multiply service,
// a negedge compare process, and directed cases that pin latency and arithmetic.
module tb_alu_mul_sequencer;
  localparam int DW = 32;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

  alu_mul_sequencer #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Simple ALU standing in for the core's
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_result = bus.alu_srca & bus.alu_srcb;
      4'b0001: bus.alu_result = bus.alu_srca | bus.alu_srcb;
      4'b0010: bus.alu_result = bus.alu_srca + bus.alu_srcb;
      4'b0110: bus.alu_result = bus.alu_srca - bus.alu_srcb;
      default: bus.alu_result = '0;
    endcase
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 multiplying (k steps completed), 2 result pulse
  int          m_phase = 0;
  int          m_k     = 0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_prod = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_prod  = '0;
    end else begin
      case (m_phase)
        0: if (bus.start && !bus.flush) begin
             m_phase = 1; m_k = 0; m_a = bus.op_a; m_b = bus.op_b;
           end
        1: if (bus.flush) m_phase = 0;
           else begin
             m_k++;
             if (m_k == DW) begin
               m_prod  = m_a * m_b;
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [DW-1:0] mask;
    if (chk_en) begin
      chk("ready",   {31'd0, bus.ready}, {31'd0, m_phase == 0});
      chk("busy",    {31'd0, bus.busy},  {31'd0, m_phase == 1});
      chk("done",    {31'd0, bus.done},  {31'd0, m_phase == 2});
      chk("product", bus.product, m_prod);
      if (m_phase == 1) begin
        mask = (32'd1 << m_k) - 32'd1;
        chk("alu_op_busy",   {28'd0, bus.alu_op}, 32'd2);
        chk("alu_srca_busy", bus.alu_srca, m_a * (m_b & mask));
        chk("alu_srcb_busy", bus.alu_srcb, m_b[m_k] ? (m_a << m_k) : 32'd0);
      end else begin
        chk("alu_op_pass",   {28'd0, bus.alu_op}, {28'd0, bus.core_op});
        chk("alu_srca_pass", bus.alu_srca, bus.core_srca);
        chk("alu_srcb_pass", bus.alu_srcb, bus.core_srcb);
      end
    end
  end

  task automatic rand_core();
    bus.core_op   = 4'($urandom);
    bus.core_srca = $urandom;
    bus.core_srcb = $urandom;
  endtask

  // Issue one multiply from IDLE; return product at the done cycle, done latency and busy cycles
  task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] p, output int lat, output int nbusy);
    bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; nbusy = 0; p = '0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.busy) nbusy++;
      if (bus.done) break;
    end
    p = bus.product;
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] p;
  int lat, nbusy, n, ndone, wd;
  int dcyc[$];
  logic [DW-1:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.core_op = '0; bus.core_srca = '0; bus.core_srcb = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("reset_ready",   {31'd0, bus.ready}, 32'd1);
    chk("reset_product", bus.product, 32'd0);

    // Basic 7x6 with latency pinned
    run_mul(32'd7, 32'd6, p, lat, nbusy);
    chk("basic_done_latency", lat, 32'd33);
    chk("basic_busy_cycles",  nbusy, 32'd32);
    chk("basic_product",      p, 32'd42);
    @(negedge clk);
    chk("basic_ready_again",  {31'd0, bus.ready}, 32'd1);
    @(posedge clk); #1;

    // Wrap-around cases
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, nbusy);
    chk("wrap_ones", p, 32'h0000_0001);
    run_mul(32'h0001_0000, 32'h0001_0000, p, lat, nbusy);
    chk("wrap_2p32", p, 32'h0000_0000);

    // Mux: pass-through in IDLE, ALU owned in BUSY
    bus.core_op = 4'b0110; bus.core_srca = 32'd5; bus.core_srcb = 32'd3;
    @(negedge clk);
    chk("mux_idle_op",   {28'd0, bus.alu_op}, 32'h6);
    chk("mux_idle_srca", bus.alu_srca, 32'd5);
    chk("mux_idle_srcb", bus.alu_srcb, 32'd3);
    @(posedge clk); #1;
    bus.op_a = 32'd5; bus.op_b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("mux_busy_op",    {28'd0, bus.alu_op}, 32'h2);
    chk("mux_busy_srca0", bus.alu_srca, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("mux_busy_srca2", bus.alu_srca, 32'd15);
    wd = 0;
    while (!bus.ready && wd < 50) begin @(posedge clk); #1; wd++; end
    chk("mux_back_idle", {31'd0, bus.ready}, 32'd1);

    // Flush: 3x4 completes, then 9x9 is aborted on its 10th BUSY cycle
    run_mul(32'd3, 32'd4, p, lat, nbusy);
    chk("flush_pre_product", p, 32'd12);
    bus.op_a = 32'd9; bus.op_b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush_idle_next", {31'd0, bus.ready}, 32'd1);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    chk("flush_no_done",      ndone, 32'd0);
    chk("flush_product_kept", bus.product, 32'd12);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_rejected", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: start held high with operands changing every cycle
    bus.start = 1'b1;
    for (n = 0; n < 110; n++) begin
      @(negedge clk);
      if (bus.done) dcyc.push_back(n);
      @(posedge clk); #1;
      bus.op_a = $urandom; bus.op_b = $urandom;
    end
    bus.start = 1'b0;
    chk("b2b_done_count", dcyc.size(), 32'd3);
    if (dcyc.size() >= 2) chk("b2b_spacing", dcyc[1] - dcyc[0], 32'd34);
    wd = 0;
    while (!bus.ready && wd < 50) begin @(posedge clk); #1; wd++; end
    chk("b2b_back_idle", {31'd0, bus.ready}, 32'd1);

    // Randomised operations with occasional flushes and changing core traffic
    for (int op = 0; op < 25; op++) begin
      repeat ($urandom_range(0, 3)) begin rand_core(); @(posedge clk); #1; end
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h8000_0000;
        2: ra = 32'd0;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.op_a = ra; bus.op_b = rb; bus.start = 1'b1;
      bus.flush = ($urandom_range(0, 9) == 0);
      rand_core();
      @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
      wd = 0;
      while (!bus.ready && wd < 50) begin
        bus.flush = ($urandom_range(0, 40) == 0);
        rand_core();
        @(posedge clk); #1;
        wd++;
      end
      bus.flush = 1'b0;
      chk("rand_back_idle", {31'd0, bus.ready}, 32'd1);
    end

    // Reset held two cycles in the middle of a multiply
    bus.core_op = 4'b0001; bus.core_srca = 32'hA5A5_0000; bus.core_srcb = 32'h0000_5A5A;
    bus.op_a = 32'd123; bus.op_b = 32'd456; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_busy",    {31'd0, bus.busy},  32'd0);
    chk("rst_done",    {31'd0, bus.done},  32'd0);
    chk("rst_ready",   {31'd0, bus.ready}, 32'd1);
    chk("rst_product", bus.product, 32'd0);
    chk("rst_pass_op", {28'd0, bus.alu_op}, 32'h1);
    chk("rst_pass_a",  bus.alu_srca, 32'hA5A5_0000);
    rst_n = 1'b1;
    run_mul(32'hFFFF_FFFE, 32'd3, p, lat, nbusy);
    chk("post_rst_product", p, 32'hFFFF_FFFA);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=<500000", $time);
    $fatal(1, "timeout");
  end
endmodule
